// File: rtl/cond_unit.sv
// Conditional-execution unit: architectural NZCV flag register, latched condition result
// and condition-gated write enables. Define COND_NV_TRAP_EN to add the registered Undef output.
module cond_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       CondLatch,
   input  logic       PCS,
   input  logic       NextPC,
   input  logic       RegW,
   input  logic       MemW,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       CondEx,
   output logic [3:0] Flags
`ifdef COND_NV_TRAP_EN
   ,
   output logic       Undef
`endif
);

   // Evaluates a 4-bit condition code against {N,Z,C,V}; NV never passes.
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n;
      logic z;
      logic c;
      logic v;
      logic res;
      {n, z, c, v} = nzcv;
      case (cond)
         4'b0000: res = z;
         4'b0001: res = ~z;
         4'b0010: res = c;
         4'b0011: res = ~c;
         4'b0100: res = n;
         4'b0101: res = ~n;
         4'b0110: res = v;
         4'b0111: res = ~v;
         4'b1000: res = c & ~z;
         4'b1001: res = ~c | z;
         4'b1010: res = (n == v);
         4'b1011: res = (n != v);
         4'b1100: res = ~z & (n == v);
         4'b1101: res = z | (n != v);
         4'b1110: res = 1'b1;
         4'b1111: res = 1'b0;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   logic [3:0] flags_r;
   logic [3:0] flags_next_s;
   logic       cond_ex_r;
   logic       cond_ex_next_s;
   logic       cond_now_s;

   // Next-state selection; flag writes are qualified by the pre-edge CondEx, and the
   // condition uses the pre-edge flag register (no bypass from ALUFlags).
   always_comb begin
      cond_now_s     = cond_eval(Cond, flags_r);
      cond_ex_next_s = cond_ex_r;
      flags_next_s   = flags_r;
      if (CondLatch) begin
         cond_ex_next_s = cond_now_s;
      end else begin
         cond_ex_next_s = cond_ex_r;
      end
      if (FlagW[1] & cond_ex_r) begin
         flags_next_s[3:2] = ALUFlags[3:2];
      end else begin
         flags_next_s[3:2] = flags_r[3:2];
      end
      if (FlagW[0] & cond_ex_r) begin
         flags_next_s[1:0] = ALUFlags[1:0];
      end else begin
         flags_next_s[1:0] = flags_r[1:0];
      end
   end

   // Flag and condition-result state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_r   <= 4'b0000;
         cond_ex_r <= 1'b0;
      end else begin
         flags_r   <= flags_next_s;
         cond_ex_r <= cond_ex_next_s;
      end
   end

`ifdef COND_NV_TRAP_EN
   logic undef_r;
   logic undef_next_s;

   // Next value of the NV trap bit, captured alongside CondEx.
   always_comb begin
      undef_next_s = undef_r;
      if (CondLatch) begin
         undef_next_s = (Cond == 4'b1111);
      end else begin
         undef_next_s = undef_r;
      end
   end

   // NV trap register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         undef_r <= 1'b0;
      end else begin
         undef_r <= undef_next_s;
      end
   end

   assign Undef = undef_r;
`endif

   assign Flags    = flags_r;
   assign CondEx   = cond_ex_r;
   // NextPC keeps fetch moving even while the current instruction is squashed.
   assign PCWrite  = (PCS & cond_ex_r) | NextPC;
   assign RegWrite = RegW & cond_ex_r;
   assign MemWrite = MemW & cond_ex_r;

endmodule
